// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Integer register file with a per-register pending-write scoreboard and a
//   configurable number of combinational read ports. Decode reads operands and
//   sees RAW hazards through the busy flags. Writeback commits data and retires
//   pending writes.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     When defined, a read port addressing the register being written this
//     cycle returns the incoming writeback data. Its busy flag reflects the
//     post-writeback count. busyVec is never bypassed.
//
// Parameters
//   XLEN  data width
//   NREGS number of registers (power of two, >= 2)
//   NREAD number of read ports (>= 1)
//   PCNT  maximum outstanding writes per register
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high; clears data and all counters
//   enable      writeback enable
//   rdAdrs      writeback destination
//   rdData      writeback data
//   issueValid  an instruction targeting issueAdrs issues this cycle
//   issueAdrs   destination of the issuing instruction
//   issueReady  the pending count of issueAdrs is below PCNT
//   rsAdrs      packed read addresses, port i at [i*AW +: AW]
//   rsData      packed read data, port i at [i*XLEN +: XLEN]
//   rsBusy      per-port busy flag (pending count of the addressed reg != 0)
//   busyVec     per-register busy flag
//
// Issue handshake: an issue takes effect (and increments the pending count)
// only on an edge where issueValid and issueReady are both high. issueReady
// depends only on issueAdrs and the current count, never on issueValid, so an
// issue presented while issueReady is low is dropped and upstream must hold it
// until issueReady rises.
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int PCNT  = 3,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = $clog2(PCNT + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [AW-1:0]         rdAdrs,
    input  logic [XLEN-1:0]       rdData,
    input  logic                  issueValid,
    input  logic [AW-1:0]         issueAdrs,
    output logic                  issueReady,
    input  logic [NREAD*AW-1:0]   rsAdrs,
    output logic [NREAD*XLEN-1:0] rsData,
    output logic [NREAD-1:0]      rsBusy,
    output logic [NREGS-1:0]      busyVec
);

    localparam logic [CW-1:0] PMAX = CW'(PCNT);

    logic [XLEN-1:0] mem [NREGS];
    logic [CW-1:0]   cnt [NREGS];

    // Register 0 is never counted, so it always accepts an issue.
    assign issueReady = (issueAdrs == '0) || (cnt[issueAdrs] < PMAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
        end else begin
            // Data is committed regardless of the busy state of the target.
            if (enable && (rdAdrs != '0))
                mem[rdAdrs] <= rdData;

            // Simultaneous issue and retire on one register cancel out.
            // A retire with a zero count writes data but cannot underflow.
            for (int r = 1; r < NREGS; r++) begin
                logic inc, dec;
                inc = issueValid && issueReady && (issueAdrs == AW'(r));
                dec = enable && (rdAdrs == AW'(r)) && (cnt[r] != '0);
                if (inc && !dec)
                    cnt[r] <= cnt[r] + CW'(1);
                else if (dec && !inc)
                    cnt[r] <= cnt[r] - CW'(1);
            end
            cnt[0] <= '0;
        end
    end

    always_comb begin
        busyVec = '0;
        for (int r = 1; r < NREGS; r++)
            busyVec[r] = (cnt[r] != '0);
    end

    always_comb begin
        rsData = '0;
        rsBusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] a;
            a = rsAdrs[i*AW +: AW];
            if (a != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (enable && (rdAdrs == a)) begin
                    // Post-writeback view: a count of 1 is retiring now.
                    rsData[i*XLEN +: XLEN] = rdData;
                    rsBusy[i]              = (cnt[a] > CW'(1));
                end else begin
                    rsData[i*XLEN +: XLEN] = mem[a];
                    rsBusy[i]              = (cnt[a] != '0);
                end
`else
                rsData[i*XLEN +: XLEN] = mem[a];
                rsBusy[i]              = (cnt[a] != '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int PCNT  = 3;
    localparam int AW    = 5;

    logic                  clock;
    logic                  reset;
    logic                  enable;
    logic [AW-1:0]         rdAdrs;
    logic [XLEN-1:0]       rdData;
    logic                  issueValid;
    logic [AW-1:0]         issueAdrs;
    logic                  issueReady;
    logic [NREAD*AW-1:0]   rsAdrs;
    logic [NREAD*XLEN-1:0] rsData;
    logic [NREAD-1:0]      rsBusy;
    logic [NREGS-1:0]      busyVec;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    regfile_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .PCNT(PCNT)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .rdAdrs(rdAdrs), .rdData(rdData),
        .issueValid(issueValid), .issueAdrs(issueAdrs), .issueReady(issueReady),
        .rsAdrs(rsAdrs), .rsData(rsData), .rsBusy(rsBusy), .busyVec(busyVec)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard compare: pops the oldest expectation
    task automatic chk(input string tag, input logic [XLEN-1:0] obs);
        logic [XLEN-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, expected queue empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    // driver: advance one edge, inputs change 1 time unit after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        enable     = 1'b0;
        issueValid = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        enable = 1'b1; rdAdrs = a; rdData = d;
        step();
        enable = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        issueValid = 1'b1; issueAdrs = a;
        step();
        issueValid = 1'b0;
    endtask

    // read two ports and check data and busy of both
    task automatic rd(input string tag,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                      input logic b0, input logic b1);
        rsAdrs[AW-1:0]    = a0;
        rsAdrs[2*AW-1:AW] = a1;
        exp_q.push_back(d0);
        exp_q.push_back(d1);
        exp_q.push_back({31'd0, b0});
        exp_q.push_back({31'd0, b1});
        #1;
        chk({tag, "_d0"}, rsData[XLEN-1:0]);
        chk({tag, "_d1"}, rsData[2*XLEN-1:XLEN]);
        chk({tag, "_b0"}, {31'd0, rsBusy[0]});
        chk({tag, "_b1"}, {31'd0, rsBusy[1]});
    endtask

    task automatic ready_chk(input string tag, input logic [AW-1:0] a, input logic e);
        issueAdrs = a;
        exp_q.push_back({31'd0, e});
        #1;
        chk(tag, {31'd0, issueReady});
    endtask

    task automatic bv_chk(input string tag, input logic [NREGS-1:0] e);
        exp_q.push_back(e);
        #1;
        chk(tag, busyVec);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rdAdrs = '0; rdData = '0;
        issueValid = 1'b0; issueAdrs = '0; rsAdrs = '0;
        step();
        step();
        idle();

        // reset state on every register and port
        for (int r = 0; r < NREGS; r++) begin
            rd("rst", AW'(r), AW'(NREGS - 1 - r), '0, '0, 1'b0, 1'b0);
            ready_chk("rst_ready", AW'(r), 1'b1);
        end
        bv_chk("rst_busyvec", '0);

        // basic writes
        wb(5'd1, 32'd20);
        wb(5'd2, 32'd286);
        wb(5'd4, 32'd1024);
        rd("wr12", 5'd1, 5'd2, 32'd20, 32'd286, 1'b0, 1'b0);
        rd("wr4", 5'd4, 5'd4, 32'd1024, 32'd1024, 1'b0, 1'b0);
        enable = 1'b0; rdAdrs = 5'd5; rdData = 32'd12;
        step();
        rd("noen", 5'd5, 5'd1, '0, 32'd20, 1'b0, 1'b0);
        wb(5'd0, 32'hFFFF_FFFF);
        rd("x0", 5'd0, 5'd0, '0, '0, 1'b0, 1'b0);

        // saturate x3 at PCNT, then retire
        issue(5'd3);
        ready_chk("x3_ready1", 5'd3, 1'b1);
        issue(5'd3);
        issue(5'd3);
        ready_chk("x3_full", 5'd3, 1'b0);
        bv_chk("x3_busyvec", 32'h0000_0008);
        issue(5'd3);                      // dropped: not ready
        ready_chk("x3_still_full", 5'd3, 1'b0);
        wb(5'd3, 32'd31);
        rd("x3_wb1", 5'd3, 5'd1, 32'd31, 32'd20, 1'b1, 1'b0);
        ready_chk("x3_ready_again", 5'd3, 1'b1);
        wb(5'd3, 32'd32);
        rd("x3_wb2", 5'd1, 5'd3, 32'd20, 32'd32, 1'b0, 1'b1);
        wb(5'd3, 32'd33);
        rd("x3_wb3", 5'd3, 5'd3, 32'd33, 32'd33, 1'b0, 1'b0);
        bv_chk("x3_clear", '0);

        // simultaneous issue and retire on x7
        issue(5'd7);
        issueValid = 1'b1; issueAdrs = 5'd7;
        enable = 1'b1; rdAdrs = 5'd7; rdData = 32'd77;
        step();
        idle();
        rd("x7_both", 5'd7, 5'd7, 32'd77, 32'd77, 1'b1, 1'b1);
        bv_chk("x7_busyvec", 32'h0000_0080);
        wb(5'd7, 32'd78);
        rd("x7_retire", 5'd7, 5'd0, 32'd78, '0, 1'b0, 1'b0);

        // retire with zero count: no underflow
        wb(5'd8, 32'd55);
        rd("x8_wb", 5'd8, 5'd8, 32'd55, 32'd55, 1'b0, 1'b0);
        ready_chk("x8_ready", 5'd8, 1'b1);
        issue(5'd8);
        rd("x8_issued", 5'd8, 5'd1, 32'd55, 32'd20, 1'b1, 1'b0);
        wb(5'd8, 32'd56);
        rd("x8_retired", 5'd8, 5'd8, 32'd56, 32'd56, 1'b0, 1'b0);

        // same-cycle write and read of x6
        wb(5'd6, 32'd5);
        enable = 1'b1; rdAdrs = 5'd6; rdData = 32'd99;
`ifdef REGFILE_BYPASS_EN
        rd("x6_same", 5'd6, 5'd6, 32'd99, 32'd99, 1'b0, 1'b0);
`else
        rd("x6_same", 5'd6, 5'd6, 32'd5, 32'd5, 1'b0, 1'b0);
`endif
        step();
        enable = 1'b0;
        rd("x6_next", 5'd6, 5'd6, 32'd99, 32'd99, 1'b0, 1'b0);

        // reset wins over write and issue on the same edge
        issue(5'd9);
        reset = 1'b1;
        enable = 1'b1; rdAdrs = 5'd5; rdData = 32'd12;
        issueValid = 1'b1; issueAdrs = 5'd5;
        step();
        idle();
        rd("rst_mid", 5'd5, 5'd1, '0, '0, 1'b0, 1'b0);
        rd("rst_mid2", 5'd9, 5'd6, '0, '0, 1'b0, 1'b0);
        bv_chk("rst_mid_busyvec", '0);
        ready_chk("rst_mid_ready", 5'd5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
